// File: rtl/output_write_switch_if.sv
// Output write switch bus: request/valid/last from the input channels plus the
// output FIFO full flag, and grant/ack/write/select/busy back from the switch.
//   req, in_valid, last : per-channel request, FIFO-not-empty and end-of-packet
//   out_full            : output FIFO full
//   gnt, ack            : one-hot grant and per-beat transfer acknowledge
//   out_wr, out_sel     : output FIFO write strobe and data-mux select
//   busy                : switch is holding a grant
interface output_write_switch_if #(
    parameter int unsigned NUMBER_CHANNELS = 5
);
    localparam int unsigned SEL_W = $clog2(NUMBER_CHANNELS);

    logic [NUMBER_CHANNELS-1:0] req;
    logic [NUMBER_CHANNELS-1:0] in_valid;
    logic [NUMBER_CHANNELS-1:0] last;
    logic                       out_full;
    logic [NUMBER_CHANNELS-1:0] gnt;
    logic [NUMBER_CHANNELS-1:0] ack;
    logic                       out_wr;
    logic [SEL_W-1:0]           out_sel;
    logic                       busy;

    // Channel/FIFO side drives requests and observes the switch
    modport master (
        output req, in_valid, last, out_full,
        input  gnt, ack, out_wr, out_sel, busy
    );

    // Switch side
    modport slave (
        input  req, in_valid, last, out_full,
        output gnt, ack, out_wr, out_sel, busy
    );
endinterface

// File: rtl/output_write_switch.sv
// Output write switch: one per router output port. Round-robin arbitration among
// the input channels, grant held for a whole packet (or MAX_BURST beats), per-beat
// acks to the granted input, and output FIFO write strobe / data-mux select.
//   clk, rst : clock and synchronous active-high reset
//   sw       : switch bus (slave side), see output_write_switch_if
module output_write_switch #(
    parameter int unsigned NUMBER_CHANNELS = 5,
    parameter int unsigned MAX_BURST       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output_write_switch_if.slave  sw
);
    localparam int unsigned N     = NUMBER_CHANNELS;
    localparam int unsigned SEL_W = $clog2(N);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] rr_q, rr_d;

    logic [N-1:0]     ack_c;
    logic             beat_c;
    logic             found_c;
    logic [SEL_W-1:0] pick_c;

    // Per-beat transfer: granted channel has data and the output FIFO has room
    assign ack_c  = gnt_q & sw.in_valid & {N{~sw.out_full}};
    assign beat_c = |ack_c;

    // Circular search starting just after the last released channel
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!found_c && sw.req[SEL_W'((32'(rr_q) + k) % N)]) begin
                found_c = 1'b1;
                pick_c  = SEL_W'((32'(rr_q) + k) % N);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found_c) begin
                    gnt_d   = N'(1) << pick_c;
                    sel_d   = pick_c;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (beat_c) begin
                    // Release on end of packet or when the burst limit is reached
                    if (sw.last[sel_q] || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        gnt_d   = '0;
                        rr_d    = sel_q;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= SEL_W'(N - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    assign sw.gnt     = gnt_q;
    assign sw.out_sel = sel_q;
    assign sw.busy    = (state_q == GRANT);
    assign sw.ack     = ack_c;
    assign sw.out_wr  = beat_c;
endmodule
